elevator_request_panel: RTL and testbench
=========================================

// Module: elevator_request_panel
// PURPOSE
//  Producer side of the floor_request interface consumed by the elevator controller.
//  Synchronises and debounces raw per-floor call buttons, then latches each press as a pending request.
//  Holds every request until the controller services it (door open at that floor for a full dwell), then clears it.
//  Sits between the button I/O pins and the controller's floor_request input; reads back current_floor/door_open.
// PARAMETERS
//  NUM_FLOORS       5   number of floors / request bits (floor codes 0..NUM_FLOORS-1)
//  DEBOUNCE_CYCLES  4   consecutive stable-high synchronised samples required to accept a press (>=1)
//  DWELL_CYCLES     8   consecutive door_open cycles at a requested floor required to clear it (>=1)
// PORTS
//  clk            in   1           system clock, all logic on rising edge
//  rst_n          in   1           asynchronous active-low reset
//  button         in   NUM_FLOORS  raw asynchronous call buttons, bit i = floor i, active-high
//  current_floor  in   3           floor code from controller
//  door_open      in   1           controller door-open indication
//  move_up        in   1           controller moving up
//  move_down      in   1           controller moving down
//  floor_request  out  NUM_FLOORS  registered pending requests, bit i = floor i
//  dwell_active   out  1           high while dwell timer runs
//  served_pulse   out  1           one-cycle pulse when a request is cleared
//  served_floor   out  3           floor code cleared; valid with served_pulse, holds last value otherwise
// BEHAVIOUR
//  Reset (async, rst_n=0): floor_request=0, dwell_active=0, served_pulse=0, served_floor=0,
//   sync flops/debounce counters/armed flags=0, FSM=IDLE. Reset mid-dwell drops all pending requests.
//  Input path per bit: 2-flop synchroniser -> debouncer. Counter increments while sync=1 and saturates at DEBOUNCE_CYCLES.
//   Counter clears to 0 on any sync=0 sample.
//   press pulse (1 cycle) when counter reaches DEBOUNCE_CYCLES and the bit is armed; armed clears on press.
//   armed re-sets only after sync=0. A held button therefore yields exactly one press.
//  Latency: button high and stable -> floor_request[i]=1 on the DEBOUNCE_CYCLES+3rd rising edge, counting the first sampling edge.
//  Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no request.
//  Pending set: press[i] sets floor_request[i]; setting an already-set bit is a no-op.
//  Dwell FSM, states IDLE / DWELL / CLEAR:
//   IDLE : door_open && current_floor<NUM_FLOORS && floor_request[current_floor] -> DWELL.
//          On entry: latch target=current_floor, cnt=1.
//   DWELL: dwell_active=1. Abort to IDLE with the request kept when any of these holds:
//          !door_open, move_up, move_down, or current_floor!=target.
//          Else if cnt==DWELL_CYCLES -> CLEAR, else cnt++.
//   CLEAR: floor_request[target]<=0, served_pulse=1, served_floor=target; -> IDLE unconditionally.
//  Dwell timing: with DWELL_CYCLES=N and door_open continuous, served_pulse is seen N+1 cycles after the IDLE->DWELL edge.
//  Simultaneous press[target] and CLEAR on the same edge: set wins, bit stays 1 (a new call arrived during service).
//  Presses on other floors during DWELL/CLEAR are accepted normally.
//  current_floor>=NUM_FLOORS: treated as no floor, never enters DWELL.
//  cnt width: $clog2(DWELL_CYCLES+1); no wrap is possible because cnt stops at DWELL_CYCLES.
// STRUCTURE
//  Package elevator_pkg: FLOOR_W=3; floor codes GROUND=0, FIRST=1, SECOND=2, THIRD=3, FOURTH=4;
//   dwell_state_t enum {IDLE, DWELL, CLEAR}. Shared with the controller.
//  Sub-module button_debouncer: synchroniser, counter and armed flag for one bit, with parameter DEBOUNCE_CYCLES.
//   Instantiated NUM_FLOORS times via generate.
//  Top level holds the pending register and the dwell FSM.
// TESTING
//  1 Reset: assert rst_n=0 mid-dwell with floor_request=5'b10110 -> all outputs 0 asynchronously; FSM IDLE after release.
//  2 Press: button[3] high 20 cycles, defaults -> floor_request=5'b01000 exactly on edge 7.
//    Single set only; release then re-press -> no change (already pending).
//  3 Glitch: button[2] high 3 cycles then low -> floor_request stays 0.
//  4 Service: pending[1], current_floor=1, door_open held -> served_pulse on edge 9 after DWELL entry.
//    Also served_floor=1 and floor_request[1]=0 that cycle.
//  5 Abort: same as 4 but door_open drops after 4 cycles -> no served_pulse, floor_request[1] stays 1, FSM IDLE.
//    Reopen -> full dwell restarts.
//  6 Collision: fresh press[1] debounced on the CLEAR edge of floor 1 -> served_pulse=1 and floor_request[1] remains 1.
//    Separately, current_floor=3'd6 with door_open -> never dwell.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request panel and the controller.
//   FLOOR_W        width of a floor code
//   GROUND..FOURTH named floor codes
//   dwell_state_t  dwell/service FSM states
package elevator_pkg;

    localparam int FLOOR_W = 3;

    localparam logic [FLOOR_W-1:0] GROUND = 3'd0;
    localparam logic [FLOOR_W-1:0] FIRST  = 3'd1;
    localparam logic [FLOOR_W-1:0] SECOND = 3'd2;
    localparam logic [FLOOR_W-1:0] THIRD  = 3'd3;
    localparam logic [FLOOR_W-1:0] FOURTH = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        CLEAR = 2'd2
    } dwell_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One call-button input path: 2-flop synchroniser, saturating stable-high
// counter and an armed flag so a held button yields a single press.
//   clk, rst_n  clock, async active-low reset
//   button      raw asynchronous button (active-high)
//   press       one-cycle pulse when a debounced press is accepted
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             meta;
    logic             sync;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // Combinational so the pending bit sets on the edge after the counter saturates.
    assign press = armed && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            meta <= button;
            sync <= meta;
            if (!sync) begin
                // A low sample ends the press and re-arms for the next one.
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
                if (press)
                    armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/elevator_request_panel.sv
// Call-button panel: debounces per-floor buttons, latches presses as pending
// floor requests and clears a request once the door has stayed open at that
// floor for a full dwell.
//   clk, rst_n     clock, async active-low reset
//   button         raw call buttons, bit i = floor i
//   current_floor  floor code from controller
//   door_open      controller door-open indication
//   move_up/down   controller motion indications
//   floor_request  pending requests (registered)
//   dwell_active   high while the dwell timer runs
//   served_pulse   one-cycle pulse when a request is cleared
//   served_floor   floor code of the last cleared request
module elevator_request_panel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_CYCLES    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] button,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  move_up,
    input  logic                  move_down,
    output logic [NUM_FLOORS-1:0] floor_request,
    output logic                  dwell_active,
    output logic                  served_pulse,
    output logic [FLOOR_W-1:0]    served_floor
);

    localparam int              CNT_W     = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES);

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic                  req_here;
    logic                  stay;

    dwell_state_t          state;
    logic [FLOOR_W-1:0]    target;
    logic [CNT_W-1:0]      cnt;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .button (button[i]),
            .press  (press[i])
        );
    end

    // Codes at or above NUM_FLOORS match no bit, so they never start a dwell.
    always_comb begin
        req_here = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (current_floor == FLOOR_W'(i))
                req_here = floor_request[i];
    end

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (state == CLEAR && target == FLOOR_W'(i))
                clr_mask[i] = 1'b1;
    end

    assign stay = door_open && !move_up && !move_down && (current_floor == target);

    // A press landing on the clear edge wins: a new call arrived during service.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            floor_request <= '0;
        else
            floor_request <= (floor_request & ~clr_mask) | press;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            target       <= GROUND;
            cnt          <= '0;
            dwell_active <= 1'b0;
            served_pulse <= 1'b0;
            served_floor <= GROUND;
        end else begin
            served_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (door_open && req_here) begin
                        state        <= DWELL;
                        target       <= current_floor;
                        cnt          <= CNT_W'(1);
                        dwell_active <= 1'b1;
                    end
                end
                DWELL: begin
                    if (!stay) begin
                        // Interrupted service: the request stays pending.
                        state        <= IDLE;
                        dwell_active <= 1'b0;
                    end else if (cnt == DWELL_MAX) begin
                        state        <= CLEAR;
                        dwell_active <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    served_pulse <= 1'b1;
                    served_floor <= target;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_request_panel.sv
// Bench for elevator_request_panel: directed scenario tasks with constant
// expectations plus a randomized run checked against a behavioural model.
module tb_elevator_request_panel;

    localparam int NF  = 5;
    localparam int DEB = 4;
    localparam int DWL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] button = '0;
    logic [2:0]    current_floor = '0;
    logic          door_open = 1'b0;
    logic          move_up = 1'b0;
    logic          move_down = 1'b0;
    logic [NF-1:0] floor_request;
    logic          dwell_active;
    logic          served_pulse;
    logic [2:0]    served_floor;

    int checks = 0;
    int errors = 0;

    elevator_request_panel #(
        .NUM_FLOORS      (NF),
        .DEBOUNCE_CYCLES (DEB),
        .DWELL_CYCLES    (DWL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .current_floor (current_floor),
        .door_open     (door_open),
        .move_up       (move_up),
        .move_down     (move_down),
        .floor_request (floor_request),
        .dwell_active  (dwell_active),
        .served_pulse  (served_pulse),
        .served_floor  (served_floor)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Buttons: a press is accepted once the button, seen two clocks late,
    // has been high for DEB consecutive samples, once per high run.
    // Dwell: m_age counts clocks of uninterrupted service; 1..DWL is the
    // timed dwell, DWL+1 is the clearing clock.
    logic [NF-1:0] m_req, m_d1, m_d2, m_fresh, m_press, m_seen, m_clr;
    int            m_run [NF];
    int            m_age, m_tgt;
    logic          m_served;
    logic [2:0]    m_sfloor;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = '0; m_d1 = '0; m_d2 = '0; m_fresh = '0;
            for (int i = 0; i < NF; i++) m_run[i] = 0;
            m_age = 0; m_tgt = 0; m_served = 1'b0; m_sfloor = '0;
        end else begin
            m_seen = m_d2;
            for (int i = 0; i < NF; i++) m_press[i] = m_fresh[i] && (m_run[i] >= DEB);
            m_clr    = '0;
            m_served = 1'b0;
            if (m_age == 0) begin
                if (door_open && int'(current_floor) < NF) begin
                    if (m_req[current_floor]) begin
                        m_age = 1;
                        m_tgt = int'(current_floor);
                    end
                end
            end else if (m_age <= DWL) begin
                if (!door_open || move_up || move_down || int'(current_floor) != m_tgt)
                    m_age = 0;
                else
                    m_age = m_age + 1;
            end else begin
                m_clr[m_tgt] = 1'b1;
                m_served     = 1'b1;
                m_sfloor     = 3'(m_tgt);
                m_age        = 0;
            end
            m_req = (m_req & ~m_clr) | m_press;
            for (int i = 0; i < NF; i++) begin
                if (!m_seen[i]) begin
                    m_run[i]   = 0;
                    m_fresh[i] = 1'b1;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_press[i]) m_fresh[i] = 1'b0;
                end
            end
            m_d2 = m_d1;
            m_d1 = button;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; button = '0; door_open = 1'b0; current_floor = '0;
        move_up = 1'b0; move_down = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic press_floors(input logic [NF-1:0] mask);
        button = mask;
        repeat (7) tick();
        button = '0;
        repeat (4) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (floor_request !== '0 || dwell_active !== 1'b0 || served_pulse !== 1'b0 || served_floor !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: req=%b dwell=%b served=%b floor=%0d, expected all zero",
                     floor_request, dwell_active, served_pulse, served_floor);
        end
        press_floors(5'b10110);
        checks++;
        if (floor_request !== 5'b10110) begin
            errors++;
            $display("FAIL reset_setup: req=%b expected 10110", floor_request);
        end
        current_floor = 3'd2; door_open = 1'b1;
        repeat (4) tick();
        checks++;
        if (dwell_active !== 1'b1) begin
            errors++;
            $display("FAIL reset_dwelling: dwell=%b expected 1", dwell_active);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (floor_request !== '0 || dwell_active !== 1'b0 || served_pulse !== 1'b0 || served_floor !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: req=%b dwell=%b served=%b floor=%0d, expected all zero",
                     floor_request, dwell_active, served_pulse, served_floor);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (dwell_active !== 1'b0 || floor_request !== '0) begin
            errors++;
            $display("FAIL reset_release: dwell=%b req=%b expected 0/00000", dwell_active, floor_request);
        end
        door_open = 1'b0;
    endtask

    task automatic test_press();
        logic [NF-1:0] exp;
        do_reset();
        button = 5'b01000;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k >= DEB + 3) ? 5'b01000 : 5'b00000;
            checks++;
            if (floor_request !== exp) begin
                errors++;
                $display("FAIL press_edge%0d: req=%b expected %b", k, floor_request, exp);
            end
        end
        button = '0;
        repeat (6) tick();
        button = 5'b01000;
        repeat (12) tick();
        button = '0;
        checks++;
        if (floor_request !== 5'b01000) begin
            errors++;
            $display("FAIL press_repress: req=%b expected 01000", floor_request);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        button = 5'b00100;
        repeat (DEB - 1) tick();
        button = '0;
        repeat (10) tick();
        checks++;
        if (floor_request !== '0) begin
            errors++;
            $display("FAIL glitch: req=%b expected 00000", floor_request);
        end
    endtask

    task automatic test_service();
        do_reset();
        press_floors(5'b00010);
        current_floor = 3'd1; door_open = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            checks++;
            if (served_pulse !== (k == DWL + 1) || dwell_active !== (k < DWL)) begin
                errors++;
                $display("FAIL service_edge%0d: served=%b dwell=%b expected %b/%b",
                         k, served_pulse, dwell_active, k == DWL + 1, k < DWL);
            end
            if (k == DWL + 1) begin
                checks++;
                if (served_floor !== 3'd1 || floor_request !== 5'b00000) begin
                    errors++;
                    $display("FAIL service_clear: floor=%0d req=%b expected 1/00000", served_floor, floor_request);
                end
            end
        end
        door_open = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        press_floors(5'b00010);
        current_floor = 3'd1; door_open = 1'b1;
        repeat (4) tick();
        door_open = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (served_pulse !== 1'b0 || dwell_active !== 1'b0 || floor_request !== 5'b00010) begin
                errors++;
                $display("FAIL abort_cycle%0d: served=%b dwell=%b req=%b expected 0/0/00010",
                         k, served_pulse, dwell_active, floor_request);
            end
        end
        door_open = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            checks++;
            if (served_pulse !== (k == DWL + 1)) begin
                errors++;
                $display("FAIL abort_redwell_edge%0d: served=%b expected %b", k, served_pulse, k == DWL + 1);
            end
        end
        door_open = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        press_floors(5'b00010);
        current_floor = 3'd1; door_open = 1'b1;
        for (int k = 0; k <= DWL + 1; k++) begin
            // First sampling edge is entry+3, so the press lands on entry+DWL+1.
            if (k == 3) button = 5'b00010;
            tick();
        end
        checks++;
        if (served_pulse !== 1'b1 || floor_request[1] !== 1'b1) begin
            errors++;
            $display("FAIL collision: served=%b req1=%b expected 1/1", served_pulse, floor_request[1]);
        end
        door_open = 1'b0; button = '0;
        repeat (5) tick();
        checks++;
        if (floor_request !== 5'b00010) begin
            errors++;
            $display("FAIL collision_kept: req=%b expected 00010", floor_request);
        end
    endtask

    task automatic test_invalid_floor();
        do_reset();
        press_floors(5'b10001);
        door_open = 1'b1;
        for (int k = 0; k < 24; k++) begin
            current_floor = (k < 12) ? 3'd6 : 3'd5;
            tick();
            checks++;
            if (dwell_active !== 1'b0 || served_pulse !== 1'b0) begin
                errors++;
                $display("FAIL invalid_floor%0d: dwell=%b served=%b expected 0/0", current_floor, dwell_active, served_pulse);
            end
        end
        door_open = 1'b0;
        checks++;
        if (floor_request !== 5'b10001) begin
            errors++;
            $display("FAIL invalid_kept: req=%b expected 10001", floor_request);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NF; i++)
                if ($urandom_range(0, 15) == 0) button[i] = ~button[i];
            if ($urandom_range(0, 19) == 0) door_open = ~door_open;
            if ($urandom_range(0, 24) == 0) current_floor = 3'($urandom_range(0, 6));
            move_up   = ($urandom_range(0, 59) == 0);
            move_down = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (floor_request !== m_req) begin
                errors++;
                $display("FAIL rand_req@%0d: got %b expected %b", n, floor_request, m_req);
            end
            checks++;
            if (dwell_active !== (m_age >= 1 && m_age <= DWL)) begin
                errors++;
                $display("FAIL rand_dwell@%0d: got %b expected %b", n, dwell_active, m_age >= 1 && m_age <= DWL);
            end
            checks++;
            if (served_pulse !== m_served || served_floor !== m_sfloor) begin
                errors++;
                $display("FAIL rand_served@%0d: got %b/%0d expected %b/%0d",
                         n, served_pulse, served_floor, m_served, m_sfloor);
            end
        end
        button = '0; door_open = 1'b0; move_up = 1'b0; move_down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_service();
        test_abort();
        test_collision();
        test_invalid_floor();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
